// File: rtl/aes128_sbox_arbiter.sv
// Round-robin burst arbiter sharing one Rijndael S-box LUT between SubBytes and key expansion.
// Optional result register: define AES128_SBOX_ARB_REG_EN to add one cycle of lookup latency.
module aes128_sbox_arbiter #(
  parameter int unsigned SB_BURST = 16,
  parameter int unsigned KS_BURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sb_req_i,
  input  logic [7:0] sb_data_i,
  output logic       sb_gnt_o,
  output logic [7:0] sb_data_o,
  output logic       sb_valid_o,
  input  logic       ks_req_i,
  input  logic [7:0] ks_data_i,
  output logic       ks_gnt_o,
  output logic [7:0] ks_data_o,
  output logic       ks_valid_o,
  output logic [7:0] sbox_sub_o,
  input  logic [7:0] sbox_sub_i,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(16) + 1;
  localparam logic [CNT_W-1:0] SB_LAST = CNT_W'(SB_BURST - 1);
  localparam logic [CNT_W-1:0] KS_LAST = CNT_W'(KS_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_SB = 2'd1,
    GNT_KS = 2'd2
  } state_e;

  typedef enum logic {
    OWN_SB = 1'b0,
    OWN_KS = 1'b1
  } owner_e;

  state_e           state_q, state_d;
  owner_e           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_e arb_state;
  owner_e arb_last;
  logic   sb_beat;
  logic   ks_beat;

  // A granted cycle only counts as a beat while its request is still held.
  assign sb_beat = (state_q == GNT_SB) && sb_req_i;
  assign ks_beat = (state_q == GNT_KS) && ks_req_i;

  always_comb begin
    arb_state = IDLE;
    arb_last  = last_q;
    if (sb_req_i && ks_req_i) begin
      if (last_q == OWN_SB) begin
        arb_state = GNT_KS;
        arb_last  = OWN_KS;
      end else begin
        arb_state = GNT_SB;
        arb_last  = OWN_SB;
      end
    end else if (sb_req_i) begin
      arb_state = GNT_SB;
      arb_last  = OWN_SB;
    end else if (ks_req_i) begin
      arb_state = GNT_KS;
      arb_last  = OWN_KS;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = arb_state;
        last_d  = arb_last;
        cnt_d   = '0;
      end
      GNT_SB: begin
        if (!sb_req_i || (cnt_q == SB_LAST)) begin
          state_d = arb_state;
          last_d  = arb_last;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GNT_KS: begin
        if (!ks_req_i || (cnt_q == KS_LAST)) begin
          state_d = arb_state;
          last_d  = arb_last;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= OWN_SB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb_gnt_o   = sb_beat;
  assign ks_gnt_o   = ks_beat;
  assign busy_o     = (state_q != IDLE);
  assign sbox_sub_o = sb_beat ? sb_data_i : (ks_beat ? ks_data_i : 8'h00);

`ifdef AES128_SBOX_ARB_REG_EN
  logic [7:0] res_data_q, res_data_d;
  logic       res_valid_q, res_valid_d;
  owner_e     res_owner_q, res_owner_d;

  // The owner bit routes a late result to its requester even after the grant moved on.
  always_comb begin
    res_valid_d = sb_beat || ks_beat;
    res_owner_d = ks_beat ? OWN_KS : OWN_SB;
    res_data_d  = (sb_beat || ks_beat) ? sbox_sub_i : 8'h00;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_data_q  <= 8'h00;
      res_valid_q <= 1'b0;
      res_owner_q <= OWN_SB;
    end else begin
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_owner_q <= res_owner_d;
    end
  end

  assign sb_valid_o = res_valid_q && (res_owner_q == OWN_SB);
  assign ks_valid_o = res_valid_q && (res_owner_q == OWN_KS);
  assign sb_data_o  = sb_valid_o ? res_data_q : 8'h00;
  assign ks_data_o  = ks_valid_o ? res_data_q : 8'h00;
`else
  assign sb_valid_o = sb_beat;
  assign ks_valid_o = ks_beat;
  assign sb_data_o  = sb_beat ? sbox_sub_i : 8'h00;
  assign ks_data_o  = ks_beat ? sbox_sub_i : 8'h00;
`endif

endmodule

// File: tb/tb_aes128_sbox_arbiter.sv
// Directed bench for aes128_sbox_arbiter: default bursts (16/4) on dut1, SB_BURST=1 / KS_BURST=16 on dut2.
module tb_aes128_sbox_arbiter;

`ifdef AES128_SBOX_ARB_REG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  // First two rows of the AES S-box (inputs 0x00..0x1F).
  localparam logic [7:0] SBOX_LO [0:31] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0
  };

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    return (x < 8'd32) ? SBOX_LO[x[4:0]] : 8'h00;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sb_req = 1'b0;
  logic [7:0] sb_data = 8'h00;
  logic       ks_req = 1'b0;
  logic [7:0] ks_data = 8'h00;

  logic       sb_gnt1, sb_valid1, ks_gnt1, ks_valid1, busy1;
  logic [7:0] sb_dout1, ks_dout1, sub_o1, sub_i1;
  logic       sb_gnt2, sb_valid2, ks_gnt2, ks_valid2, busy2;
  logic [7:0] sb_dout2, ks_dout2, sub_o2, sub_i2;

  assign sub_i1 = sbox_ref(sub_o1);
  assign sub_i2 = sbox_ref(sub_o2);

  always #5 clk = ~clk;

  aes128_sbox_arbiter #(.SB_BURST(16), .KS_BURST(4)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .sb_req_i(sb_req), .sb_data_i(sb_data), .sb_gnt_o(sb_gnt1), .sb_data_o(sb_dout1), .sb_valid_o(sb_valid1),
    .ks_req_i(ks_req), .ks_data_i(ks_data), .ks_gnt_o(ks_gnt1), .ks_data_o(ks_dout1), .ks_valid_o(ks_valid1),
    .sbox_sub_o(sub_o1), .sbox_sub_i(sub_i1), .busy_o(busy1)
  );

  aes128_sbox_arbiter #(.SB_BURST(1), .KS_BURST(16)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .sb_req_i(sb_req), .sb_data_i(sb_data), .sb_gnt_o(sb_gnt2), .sb_data_o(sb_dout2), .sb_valid_o(sb_valid2),
    .ks_req_i(ks_req), .ks_data_i(ks_data), .ks_gnt_o(ks_gnt2), .ks_data_o(ks_dout2), .ks_valid_o(ks_valid2),
    .sbox_sub_o(sub_o2), .sbox_sub_i(sub_i2), .busy_o(busy2)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    ks_pulses = 0;
  string phase = "init";

  // Expected results of the previous cycle, used when results are registered.
  logic       prev_sv = 1'b0, prev_kv = 1'b0;
  logic [7:0] prev_sd = 8'h00, prev_kd = 8'h00;

  task automatic chk(input string what, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[c%0d] %s observed=%0h expected=%0h", phase, cyc, what, obs, exp);
    end
  endtask

  task automatic check_all_zero(input bit sel);
    chk("rst_sb_gnt",   {7'd0, sel ? sb_gnt2 : sb_gnt1}, 8'h00);
    chk("rst_ks_gnt",   {7'd0, sel ? ks_gnt2 : ks_gnt1}, 8'h00);
    chk("rst_busy",     {7'd0, sel ? busy2 : busy1}, 8'h00);
    chk("rst_sbox_sub", sel ? sub_o2 : sub_o1, 8'h00);
    chk("rst_sb_valid", {7'd0, sel ? sb_valid2 : sb_valid1}, 8'h00);
    chk("rst_sb_data",  sel ? sb_dout2 : sb_dout1, 8'h00);
    chk("rst_ks_valid", {7'd0, sel ? ks_valid2 : ks_valid1}, 8'h00);
    chk("rst_ks_data",  sel ? ks_dout2 : ks_dout1, 8'h00);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    sb_req = 1'b0; ks_req = 1'b0; sb_data = 8'h00; ks_data = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    prev_sv = 1'b0; prev_kv = 1'b0; prev_sd = 8'h00; prev_kd = 8'h00;
    phase = name;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, check every output against the hand-written grant schedule.
  task automatic step(input bit sel, input logic sr, input logic [7:0] sd,
                      input logic kr, input logic [7:0] kd,
                      input logic esg, input logic ekg, input logic eb);
    logic       cur_sv, cur_kv, esv, ekv;
    logic [7:0] cur_sd, cur_kd, esd, ekd, esub;
    sb_req = sr; sb_data = sd; ks_req = kr; ks_data = kd;
    cyc++;
    #3;
    esub   = esg ? sd : (ekg ? kd : 8'h00);
    cur_sv = esg;
    cur_sd = esg ? sbox_ref(sd) : 8'h00;
    cur_kv = ekg;
    cur_kd = ekg ? sbox_ref(kd) : 8'h00;
    esv = REG_MODE ? prev_sv : cur_sv;
    esd = REG_MODE ? prev_sd : cur_sd;
    ekv = REG_MODE ? prev_kv : cur_kv;
    ekd = REG_MODE ? prev_kd : cur_kd;
    chk("sb_gnt",   {7'd0, sel ? sb_gnt2 : sb_gnt1}, {7'd0, esg});
    chk("ks_gnt",   {7'd0, sel ? ks_gnt2 : ks_gnt1}, {7'd0, ekg});
    chk("busy",     {7'd0, sel ? busy2 : busy1}, {7'd0, eb});
    chk("sbox_sub", sel ? sub_o2 : sub_o1, esub);
    chk("sb_valid", {7'd0, sel ? sb_valid2 : sb_valid1}, {7'd0, esv});
    chk("sb_data",  sel ? sb_dout2 : sb_dout1, esd);
    chk("ks_valid", {7'd0, sel ? ks_valid2 : ks_valid1}, {7'd0, ekv});
    chk("ks_data",  sel ? ks_dout2 : ks_dout1, ekd);
    if (sel ? ks_valid2 : ks_valid1) ks_pulses++;
    prev_sv = cur_sv; prev_sd = cur_sd; prev_kv = cur_kv; prev_kd = cur_kd;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset with no clock edge yet: outputs already 0.
    #2;
    check_all_zero(1'b0);

    // Idle isolation, then a single SB burst of 0x00..0x0F.
    do_reset("sb_single");
    step(0, 0, 8'hFF, 0, 8'hFF, 0, 0, 0);
    step(0, 0, 8'hFF, 0, 8'hFF, 0, 0, 0);
    step(0, 1, 8'h00, 0, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 8'hFF, 1, 0, 1);
    step(0, 0, 8'h05, 0, 8'hFF, 0, 0, 1);
    step(0, 0, 8'hFF, 0, 8'hFF, 0, 0, 0);

    // Both requests rise together: KS 4 beats, SB 16 beats, KS again.
    do_reset("simul");
    step(0, 1, 8'h00, 1, 8'h10, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h0E, 1, 8'(8'h10 + i), 0, 1, 1);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 1, 8'h1F, 1, 0, 1);
    step(0, 1, 8'h03, 1, 8'h1A, 0, 1, 1);
    step(0, 0, 8'h03, 0, 8'h1A, 0, 0, 1);
    step(0, 0, 8'h03, 0, 8'h1A, 0, 0, 0);

    // KS aborts after 2 beats while SB is pending.
    do_reset("abort");
    ks_pulses = 0;
    step(0, 1, 8'h00, 1, 8'h18, 0, 0, 0);
    step(0, 1, 8'h00, 1, 8'h18, 0, 1, 1);
    step(0, 1, 8'h00, 1, 8'h19, 0, 1, 1);
    step(0, 1, 8'h00, 0, 8'h1A, 0, 0, 1);
    step(0, 1, 8'h04, 0, 8'h1A, 1, 0, 1);
    step(0, 1, 8'h05, 0, 8'h1A, 1, 0, 1);
    step(0, 0, 8'h06, 0, 8'h1A, 0, 0, 1);
    step(0, 0, 8'h06, 0, 8'h1A, 0, 0, 0);
    chk("ks_valid_pulses", 8'(ks_pulses), 8'd2);

    // Asynchronous reset at SB beat 7, then a fresh 16-beat burst.
    do_reset("rst_mid");
    step(0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h10 + i), 0, 8'h00, 1, 0, 1);
    sb_data = 8'h17;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero(1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    prev_sv = 1'b0; prev_kv = 1'b0; prev_sd = 8'h00; prev_kd = 8'h00;
    step(0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h1F - i), 0, 8'h00, 1, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

    // SB_BURST=1, KS_BURST=16 instance.
    do_reset("bursts");
    step(1, 1, 8'h00, 1, 8'h10, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 8'h02, 1, 8'(8'h10 + i), 0, 1, 1);
    step(1, 1, 8'h0C, 1, 8'h00, 1, 0, 1);
    step(1, 1, 8'h0C, 1, 8'h1B, 0, 1, 1);
    step(1, 0, 8'h0C, 0, 8'h1B, 0, 0, 1);
    step(1, 0, 8'h0C, 0, 8'h1B, 0, 0, 0);
    step(1, 1, 8'h08, 0, 8'h1B, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h08 + i), 0, 8'h1B, 1, 0, 1);
    step(1, 0, 8'h0C, 0, 8'h1B, 0, 0, 1);
    step(1, 0, 8'h0C, 0, 8'h1B, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes128_sbox_arbiter.md
# aes128_sbox_arbiter

Shares a single Rijndael S-box LUT between the SubBytes engine and the key-expansion engine of the AES-128 peripheral. It grants the LUT in fixed-length bursts with round-robin arbitration and drives the shared LUT input. It returns each requester's substituted byte together with a valid strobe. It sits between the two requesters and the one LUT instance, which is connected through the `sbox_sub_o` / `sbox_sub_i` pair.

## Interface
- `SB_BURST`, default 16: lookups per SubBytes grant; legal range 1..16.
- `KS_BURST`, default 4: lookups per key-expansion grant (RotWord/SubWord); legal range 1..16.
- `clk_i`, input, 1: single clock; all state is on the rising edge.
- `rst_n_i`, input, 1: reset, asynchronous, active-low.
- `sb_req_i`, input, 1: SubBytes requests the LUT; held high for the whole burst.
- `sb_data_i`, input, 8: SubBytes byte to substitute; sampled on every cycle that `sb_gnt_o` is high.
- `sb_gnt_o`, output, 1: SubBytes owns the LUT this cycle (one lookup beat).
- `sb_data_o`, output, 8: substituted byte for SubBytes.
- `sb_valid_o`, output, 1: `sb_data_o` is valid.
- `ks_req_i`, `ks_data_i`, `ks_gnt_o`, `ks_data_o`, `ks_valid_o`: same as the `sb_*` ports, for key expansion.
- `sbox_sub_o`, output, 8: byte driven to the shared LUT.
- `sbox_sub_i`, input, 8: LUT result; combinational from `sbox_sub_o`.
- `busy_o`, output, 1: a grant is active.

## Operation
- States: IDLE, GNT_SB, GNT_KS.
- Beat counter: width `$clog2(16)+1` (5 bits). Cleared on every grant entry; increments once per granted cycle.
- Round-robin pointer `last`: records which requester was served most recently. Reset value is SB, so key expansion wins the first tie.
- Arbitration is evaluated in IDLE and on the final beat of a burst:
  - Only one request is high: that requester wins.
  - Both requests are high: the requester that is not `last` wins.
  - No request is high: go to IDLE.
- Entering a grant state sets `last` to that requester.
- GNT_x:
  - `x_gnt_o` = 1.
  - `sbox_sub_o` = `x_data_i`.
  - The burst ends when the beat counter reaches `x_BURST`-1 on the current cycle. The next state comes from arbitration, so back-to-back bursts are allowed and alternate when both requesters stay high.
- Abort: if `x_req_i` drops during GNT_x, that cycle is not a beat.
  - Grant is removed combinationally: `x_gnt_o` = 0 and `sbox_sub_o` = 0 that cycle.
  - The next state comes from arbitration, with `last` still updated to x.
- A requester that is not granted sees `gnt` = 0, `valid` = 0 and `data` = 0.
- `sbox_sub_o` = 0 whenever no grant is active.
- `busy_o` = state != IDLE.
- Requests are level-sensitive. A requester that re-asserts after a completed burst competes again under round robin.

## Timing
- Reset (asserted asynchronously): state = IDLE, `last` = SB, counter = 0. All outputs are 0 immediately, including `sbox_sub_o`.
- Reset mid-burst: the burst is lost without any further valid strobes. Requesters must re-request after reset deasserts.
- Request latency: `x_req_i` rising in IDLE at edge N gives `x_gnt_o` high from cycle N+1. Grant stays high for exactly `x_BURST` cycles if the request is held.
- Lookup latency without the macro (see Configuration): 0 cycles. `x_valid_o` = `x_gnt_o` and `x_data_o` = `sbox_sub_i` in the same cycle.
- Back-to-back: the last SB beat in cycle M is followed by the first KS beat in cycle M+1, with no bubble.
- Both requests rising in the same cycle from reset: KS is granted first, then SB.

## Configuration
- Macro: `AES128_SBOX_ARB_REG_EN`.
- Defined:
  - `sbox_sub_i` is captured in an 8-bit register together with a valid bit and an owner bit.
  - `x_data_o` / `x_valid_o` appear one cycle after the beat.
  - Beat order is preserved. A result from the final beat of an SB burst is delivered on `sb_*` even while KS is already granted.
  - The register resets to 0.
- Undefined: the combinational path described under Timing applies. No pipeline register is present.

## Test plan
- Single SB burst:
  - Stimulus: `sb_req_i` held high from cycle 1, `sb_data_i` = 0x00..0x0F on successive beats.
  - Required response: `sb_gnt_o` high for cycles 2..17, `sb_data_o` = 0x63, 0x7C, 0x77, 0x7B, ..., 0x76. With the macro, each result lags its beat by one cycle.
- Simultaneous requests after reset:
  - Stimulus: `sb_req_i` and `ks_req_i` both rise in cycle 1 and stay high.
  - Required response: KS granted cycles 2..5, then SB cycles 6..21, then KS again from cycle 22.
- Abort:
  - Stimulus: `ks_req_i` dropped after 2 beats while `sb_req_i` is pending.
  - Required response: `ks_gnt_o` low in the drop cycle, SB granted the next cycle, exactly 2 `ks_valid_o` pulses in total.
- Async reset mid-SB-burst at beat 7:
  - Required response: all outputs 0 without waiting for a clock edge. After release with only `sb_req_i` high, SB is granted with the beat count restarting at 0.
- Idle isolation:
  - Stimulus: no requests, `sb_data_i` = `ks_data_i` = 0xFF.
  - Required response: `sbox_sub_o` = 0x00, all `gnt`, `valid` and `busy` outputs 0.
- Burst parameters:
  - `SB_BURST` = 1: single-beat grants.
  - `KS_BURST` = 16: 16-beat grants with counter terminal value 15 and no wrap to 0 mid-burst.
